// File: rtl/ps_pkg.sv
// Shared types for the stacked program sequencer.
// Next-address select enum and target-shift helper.
package ps_pkg;

  typedef enum logic [2:0] {
    NA_RESET,
    NA_HOLD,
    NA_RET,
    NA_CALL,
    NA_JUMP,
    NA_SEQ
  } next_sel_t;

  // Jump target is {jump_address, zeros}; this is the zero count.
  function automatic int tgt_shift(input int aw, input int jw);
    return aw - jw;
  endfunction

endpackage

// File: rtl/ps_call_stack.sv
// LIFO return-address stack; only the pointer is reset.
// Ports: clk, rst_n, clr, push, pop, din -> top, empty, full.
module ps_call_stack
  import ps_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] ptr;
  logic [W-1:0]  mem [2**IW];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign empty   = (ptr == '0);
  assign full    = (ptr == PW'(DEPTH));
  assign wr_idx  = IW'(ptr);
  assign rd_idx  = IW'(ptr - PW'(1));
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && !full && !clr && !pop;
  assign top     = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (clr)
      ptr <= '0;
    else if (do_pop)
      ptr <= ptr - PW'(1);
    else if (do_push)
      ptr <= ptr + PW'(1);
  end

  // Entry storage carries no reset.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_idx] <= din;
  end

endmodule

// File: rtl/program_sequencer_stk.sv
// Program sequencer with call/return stack, stall and stack error flag.
// Ports: clk, reset_n, sync_reset, stall, jump, conditional_jump,
//   dont_jmp, call, ret, jump_address -> pm_addr, pc, from_PS,
//   stack_empty, stack_full, stack_err.
// Option PS_BRANCH_TRACE_EN adds last_branch_src and branch_cnt.
module program_sequencer_stk
  import ps_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int JADDR_W     = 4,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VEC   = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sync_reset,
  input  logic               stall,
  input  logic               jump,
  input  logic               conditional_jump,
  input  logic               dont_jmp,
  input  logic               call,
  input  logic               ret,
  input  logic [JADDR_W-1:0] jump_address,
`ifdef PS_BRANCH_TRACE_EN
  output logic [ADDR_W-1:0]  last_branch_src,
  output logic [15:0]        branch_cnt,
`endif
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  from_PS,
  output logic               stack_empty,
  output logic               stack_full,
  output logic               stack_err
);

  localparam int SH = tgt_shift(ADDR_W, JADDR_W);
  localparam logic [ADDR_W-1:0] RV = ADDR_W'(RESET_VEC);

  next_sel_t         sel;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] nxt;
  logic              err_set;
  logic              push;
  logic              pop;

  assign seq    = pc + ADDR_W'(1);
  assign target = ADDR_W'(jump_address) << SH;

  always_comb begin
    sel     = NA_SEQ;
    err_set = 1'b0;
    if (sync_reset) begin
      sel = NA_RESET;
    end else if (stall) begin
      sel = NA_HOLD;
    end else if (ret) begin
      // Underflow falls through to sequential fetch.
      if (stack_empty) err_set = 1'b1;
      else             sel     = NA_RET;
    end else if (call) begin
      if (stack_full) err_set = 1'b1;
      else            sel     = NA_CALL;
    end else if (jump || (conditional_jump && !dont_jmp)) begin
      sel = NA_JUMP;
    end
  end

  always_comb begin
    nxt = seq;
    unique case (sel)
      NA_RESET: nxt = RV;
      NA_HOLD:  nxt = pc;
      NA_RET:   nxt = from_PS;
      NA_CALL:  nxt = target;
      NA_JUMP:  nxt = target;
      NA_SEQ:   nxt = seq;
      default:  nxt = seq;
    endcase
  end

  assign pm_addr = reset_n ? nxt : RV;
  assign push    = (sel == NA_CALL);
  assign pop     = (sel == NA_RET);

  ps_call_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (sync_reset),
    .push  (push),
    .pop   (pop),
    .din   (seq),
    .top   (from_PS),
    .empty (stack_empty),
    .full  (stack_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pc <= RV;
    else
      pc <= pm_addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stack_err <= 1'b0;
    else if (sync_reset)
      stack_err <= 1'b0;
    else if (err_set)
      stack_err <= 1'b1;
  end

`ifdef PS_BRANCH_TRACE_EN
  logic taken;

  assign taken = !stall && !sync_reset && (pm_addr != seq);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_branch_src <= '0;
      branch_cnt      <= '0;
    end else if (sync_reset) begin
      last_branch_src <= '0;
      branch_cnt      <= '0;
    end else if (taken) begin
      last_branch_src <= pc;
      if (branch_cnt != 16'hFFFF)
        branch_cnt <= branch_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_program_sequencer_stk.sv
// Scoreboard bench for program_sequencer_stk (default parameters).
// Driver queues expectations; negedge monitor pops and compares.
module tb_program_sequencer_stk;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sync_reset = 1'b0;
  logic       stall = 1'b0;
  logic       jump = 1'b0;
  logic       conditional_jump = 1'b0;
  logic       dont_jmp = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [3:0] jump_address = '0;
  logic [7:0] pm_addr;
  logic [7:0] pc;
  logic [7:0] from_PS;
  logic       stack_empty;
  logic       stack_full;
  logic       stack_err;

  program_sequencer_stk dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sync_reset       (sync_reset),
    .stall            (stall),
    .jump             (jump),
    .conditional_jump (conditional_jump),
    .dont_jmp         (dont_jmp),
    .call             (call),
    .ret              (ret),
    .jump_address     (jump_address),
    .pm_addr          (pm_addr),
    .pc               (pc),
    .from_PS          (from_PS),
    .stack_empty      (stack_empty),
    .stack_full       (stack_full),
    .stack_err        (stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    pm;
    int    pc;
    int    fps;
    int    emp;
    int    full;
    int    err;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input string fld,
                     input int act, input int expv);
    if (expv < 0) return;
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "pm_addr", int'(pm_addr), e.pm);
      chk(e.nm, "pc", int'(pc), e.pc);
      chk(e.nm, "from_PS", int'(from_PS), e.fps);
      chk(e.nm, "empty", int'(stack_empty), e.emp);
      chk(e.nm, "full", int'(stack_full), e.full);
      chk(e.nm, "err", int'(stack_err), e.err);
    end
  end

  // ctl bits: {rn, sr, st, j, cj, dj, ca, re}
  task automatic step(input string nm, input logic [7:0] ctl,
                      input logic [3:0] ja, input int e_pm,
                      input int e_pc, input int e_fps, input int e_emp,
                      input int e_full, input int e_err);
    exp_t e;
    @(posedge clk);
    #2;
    {reset_n, sync_reset, stall, jump, conditional_jump,
     dont_jmp, call, ret} = ctl;
    jump_address = ja;
    e.nm = nm; e.pm = e_pm; e.pc = e_pc; e.fps = e_fps;
    e.emp = e_emp; e.full = e_full; e.err = e_err;
    q.push_back(e);
  endtask

  localparam logic [7:0] RST  = 8'b0010_0000;
  localparam logic [7:0] NONE = 8'b1000_0000;
  localparam logic [7:0] SR   = 8'b1100_0000;
  localparam logic [7:0] ST   = 8'b1010_0000;
  localparam logic [7:0] JMP  = 8'b1001_0000;
  localparam logic [7:0] CJN  = 8'b1000_1100;
  localparam logic [7:0] CJY  = 8'b1000_1000;
  localparam logic [7:0] CAL  = 8'b1000_0010;
  localparam logic [7:0] RET  = 8'b1000_0001;
  localparam logic [7:0] STC  = 8'b1010_0010;
  localparam logic [7:0] CR   = 8'b1000_0011;

  initial begin
    int budget;
    step("rst0", RST, 4'h0, 'h00, 'h00, 'h00, 1, 0, 0);
    step("rst1", RST, 4'h0, 'h00, 'h00, 'h00, 1, 0, 0);
    step("run0", NONE, 4'h0, 'h01, 'h00, 'h00, 1, 0, 0);
    step("run1", NONE, 4'h0, 'h02, 'h01, -1, -1, -1, -1);
    step("run2", NONE, 4'h0, 'h03, 'h02, -1, -1, -1, -1);
    step("jmp", JMP, 4'hA, 'hA0, 'h03, -1, -1, -1, -1);
    step("jmp_seq", NONE, 4'h0, 'hA1, 'hA0, -1, -1, -1, -1);
    step("cj_no", CJN, 4'h5, 'hA2, 'hA1, -1, -1, -1, -1);
    step("cj_yes", CJY, 4'h1, 'h10, 'hA2, -1, -1, -1, -1);
    step("s11", NONE, 4'h0, 'h11, 'h10, -1, -1, -1, -1);
    step("s12", NONE, 4'h0, 'h12, 'h11, -1, -1, -1, -1);
    step("s13", NONE, 4'h0, 'h13, 'h12, -1, -1, -1, -1);
    step("call", CAL, 4'h3, 'h30, 'h13, 'h00, 1, 0, 0);
    step("call_top", NONE, 4'h0, 'h31, 'h30, 'h14, 0, 0, 0);
    step("ret", RET, 4'h0, 'h14, 'h31, 'h14, 0, 0, 0);
    step("ret_empty", NONE, 4'h0, 'h15, 'h14, 'h00, 1, 0, 0);
    step("nest1", CAL, 4'h2, 'h20, 'h15, 'h00, 1, 0, 0);
    step("nest2", CAL, 4'h4, 'h40, 'h20, 'h16, 0, 0, 0);
    step("nest3", CAL, 4'h6, 'h60, 'h40, 'h21, 0, 0, 0);
    step("nest4", CAL, 4'h8, 'h80, 'h60, 'h41, 0, 0, 0);
    step("ovf", CAL, 4'h9, 'h81, 'h80, 'h61, 0, 1, 0);
    step("ovf_err", NONE, 4'h0, 'h82, 'h81, 'h61, 0, 1, 1);
    step("pop4", RET, 4'h0, 'h61, 'h82, 'h61, 0, 1, 1);
    step("pop3", RET, 4'h0, 'h41, 'h61, 'h41, 0, 0, 1);
    step("pop2", RET, 4'h0, 'h21, 'h41, 'h21, 0, 0, 1);
    step("pop1", RET, 4'h0, 'h16, 'h21, 'h16, 0, 0, 1);
    step("unf", RET, 4'h0, 'h17, 'h16, 'h00, 1, 0, 1);
    step("unf_err", NONE, 4'h0, 'h18, 'h17, 'h00, 1, 0, 1);
    step("sreset", SR, 4'h0, 'h00, 'h18, -1, 1, 0, 1);
    step("sr_clr", NONE, 4'h0, 'h01, 'h00, 'h00, 1, 0, 0);
    step("to_f0", JMP, 4'hF, 'hF0, 'h01, -1, -1, -1, -1);
    for (int i = 0; i < 15; i++)
      step("climb", NONE, 4'h0, 'hF1 + i, 'hF0 + i, -1, -1, -1, -1);
    step("wrap", NONE, 4'h0, 'h00, 'hFF, -1, -1, -1, -1);
    step("pre_stall", CAL, 4'h5, 'h50, 'h00, 'h00, 1, 0, 0);
    step("stall_call", STC, 4'h7, 'h50, 'h50, 'h01, 0, 0, 0);
    step("post_stall", NONE, 4'h0, 'h51, 'h50, 'h01, 0, 0, 0);
    step("s52", NONE, 4'h0, 'h52, 'h51, -1, -1, -1, -1);
    step("s53", NONE, 4'h0, 'h53, 'h52, -1, -1, -1, -1);
    step("s54", NONE, 4'h0, 'h54, 'h53, -1, -1, -1, -1);
    step("push55", CAL, 4'hC, 'hC0, 'h54, 'h01, 0, 0, 0);
    step("call_ret", CR, 4'h3, 'h55, 'hC0, 'h55, 0, 0, 0);
    step("cr_after", NONE, 4'h0, 'h56, 'h55, 'h01, 0, 0, 0);
    step("last_ret", RET, 4'h0, 'h01, 'h56, 'h01, 0, 0, 0);
    step("final", NONE, 4'h0, 'h02, 'h01, 'h00, 1, 0, 0);
    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_sequencer_stk.md
Name: program_sequencer_stk

Overview:
- Parametrised successor to the 8-bit program sequencer.
- Generates the program-memory fetch address and a registered PC, with configurable address width and jump-target width.
- Adds a hardware call/return stack, fetch stall, and stack overflow/underflow reporting.
- Sits between instruction decoder (jump/call/ret strobes) and program memory; from_PS feeds the return address to the datapath.

Parameters:
- ADDR_W, 8, program address width.
- JADDR_W, 4, jump_address width; target = {jump_address, (ADDR_W-JADDR_W) zeros}; must be <= ADDR_W.
- STACK_DEPTH, 4, return-stack entries (>=1).
- RESET_VEC, 0, fetch address after reset or sync_reset.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous reset, active low.
- sync_reset  in  1  synchronous restart, active high; functional, not power-on.
- stall  in  1  hold fetch address.
- jump  in  1  unconditional jump.
- conditional_jump  in  1  conditional jump request.
- dont_jmp  in  1  condition false; suppresses conditional_jump.
- call  in  1  push return address and jump.
- ret  in  1  pop and branch to return address.
- jump_address  in  JADDR_W  target high bits.
- pm_addr  out  ADDR_W  combinational fetch address.
- pc  out  ADDR_W  registered, = pm_addr of previous cycle.
- from_PS  out  ADDR_W  stack top (0 when empty).
- stack_empty  out  1  no entries.
- stack_full  out  1  STACK_DEPTH entries.
- stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset:
  - reset_n low: pc=RESET_VEC, stack pointer=0, stack_err=0, pm_addr forced to RESET_VEC.
  - Outputs while reset_n low: stack_empty=1, stack_full=0, from_PS=0.
- pc <= pm_addr every rising edge; pc is held under stall because pm_addr=pc then.
- pm_addr priority, highest first:
  1. sync_reset -> RESET_VEC. Stack cleared and stack_err cleared at the edge.
  2. stall -> pc. No stack change; call/ret ignored.
  3. ret -> stack top, pop.
     - If empty: pm_addr=pc+1, no pop, stack_err<=1.
  4. call -> target, push pc+1.
     - If full: pm_addr=pc+1, no push, stack_err<=1.
  5. jump -> target.
  6. conditional_jump && !dont_jmp -> target.
  7. otherwise pc+1.
- call+ret in the same cycle: ret wins, call is dropped without error. jump/conditional_jump are ignored when call or ret is active.
- Arithmetic: pc+1 is modulo 2^ADDR_W (wrap to 0). Pushed value uses the same wrap.
- Stack:
  - LIFO, pointer 0..STACK_DEPTH.
  - Push and pop update on the clock edge; from_PS reflects the new top the following cycle.
  - Entry contents are don't-care after reset; only the pointer is reset.
- stack_err clears only on reset_n or sync_reset.
- Latency: pm_addr is combinational from inputs and pc (0 cycles); pc lags by 1 cycle.

Optional Feature:
- Macro: PS_BRANCH_TRACE_EN.
- Defined: adds outputs last_branch_src (ADDR_W) and branch_cnt (16 bits).
  - On every cycle where pm_addr != pc+1 and neither stall nor sync_reset is active: last_branch_src <= pc and branch_cnt increments, saturating at FFFF.
  - Both outputs are reset to 0 by reset_n and sync_reset.
- Undefined: ports and logic are absent; behaviour otherwise identical.

Decomposition:
- Package ps_pkg:
  - Next-address-select enum {NA_RESET, NA_HOLD, NA_RET, NA_CALL, NA_JUMP, NA_SEQ}.
  - Helper constant for the target shift (ADDR_W-JADDR_W).
- Sub-module ps_call_stack (parameters DEPTH, W):
  - Inputs: push, pop, clr, din.
  - Outputs: top, empty, full.
  - The sequencer owns priority and error logic.

Test Plan:
- Reset: hold reset_n=0 with stall=1 -> pm_addr=00, pc=00, stack_empty=1. Release and run 3 cycles -> pc 00,01,02.
- Jumps:
  - jump=1, jump_address=A -> pm_addr=A0; next cycle pc=A0, pm_addr=A1.
  - conditional_jump=1 with dont_jmp=1 at pc=A1 -> pm_addr=A2.
  - conditional_jump=1 with dont_jmp=0 -> pm_addr=target.
- Call/return: call at pc=13, jump_address=3 -> pm_addr=30; next cycle from_PS=14. Later ret -> pm_addr=14, stack_empty=1.
- Overflow/underflow (depth 4):
  - Five nested calls -> fifth gives pm_addr=pc+1, stack_full=1, stack_err=1.
  - Four rets return in LIFO order; a fifth ret gives pm_addr=pc+1, stack_err stays 1.
  - sync_reset clears stack_err.
- Edge cases:
  - pc=FF with no control -> pm_addr=00.
  - stall=1 with call=1 -> pm_addr=pc, stack unchanged.
  - call+ret together with top=55 -> pm_addr=55, pointer decrements.
